// File: rtl/mpr_access_ctrl_if.sv
// Client and memory-port bundle for mpr_access_ctrl.
// The slave modport is the controller's view. The master modport is the
// view of whatever sits around it: both clients plus the dual-port memory.
interface mpr_access_ctrl_if #(
  parameter int bits = 32
);
  // Client channel 0
  logic            req_0;
  logic            we_0;
  logic [2:0]      addr_0;
  logic [bits-1:0] wdata_0;
  logic            gnt_0;
  logic            rsp_valid_0;
  logic [bits-1:0] rdata_0;

  // Client channel 1
  logic            req_1;
  logic            we_1;
  logic [2:0]      addr_1;
  logic [bits-1:0] wdata_1;
  logic            gnt_1;
  logic            rsp_valid_1;
  logic [bits-1:0] rdata_1;

  // Memory port a (fixed to channel 0)
  logic            mem_we_a;
  logic [2:0]      mem_addr_a;
  logic [bits-1:0] mem_din_a;
  logic [bits-1:0] mem_dout_a;

  // Memory port b (fixed to channel 1)
  logic            mem_we_b;
  logic [2:0]      mem_addr_b;
  logic [bits-1:0] mem_din_b;
  logic [bits-1:0] mem_dout_b;

  modport slave (
    input  req_0, we_0, addr_0, wdata_0,
    output gnt_0, rsp_valid_0, rdata_0,
    input  req_1, we_1, addr_1, wdata_1,
    output gnt_1, rsp_valid_1, rdata_1,
    output mem_we_a, mem_addr_a, mem_din_a,
    input  mem_dout_a,
    output mem_we_b, mem_addr_b, mem_din_b,
    input  mem_dout_b
  );

  modport master (
    output req_0, we_0, addr_0, wdata_0,
    input  gnt_0, rsp_valid_0, rdata_0,
    output req_1, we_1, addr_1, wdata_1,
    input  gnt_1, rsp_valid_1, rdata_1,
    input  mem_we_a, mem_addr_a, mem_din_a,
    output mem_dout_a,
    input  mem_we_b, mem_addr_b, mem_din_b,
    output mem_dout_b
  );
endinterface

// File: rtl/mpr_access_ctrl.sv
// mpr_access_ctrl: two-client access controller for an 8-entry dual-port
// register memory.
//  - Channel 0 always uses memory port a and channel 1 always uses port b.
//  - Pipeline: accept in cycle N, drive the memory from registers in N+1,
//    and pulse rsp_valid in N+2.
//  - Same-address conflicts involving a write are resolved by a
//    round-robin priority bit.
//  - Optional bulk clear, compiled in when the macro MPR_CLR_EN is defined.
//    Without it, clr_start is ignored and busy/clr_done are tied low.
module mpr_access_ctrl #(
  parameter int bits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_start,
  output logic             busy,
  output logic             clr_done,
  mpr_access_ctrl_if.slave bus
);

  // Arbitration
  logic conflict;
  logic blocked;
  logic gnt_0;
  logic gnt_1;
  logic prio_q, prio_d;                 // 0: channel 0 wins the next conflict

  // Stage N+1: a client access is occupying the memory port
  logic s1_vld_0_q, s1_vld_0_d;
  logic s1_vld_1_q, s1_vld_1_d;

  // Registered memory-port drive
  logic            mem_we_a_q,   mem_we_a_d;
  logic [2:0]      mem_addr_a_q, mem_addr_a_d;
  logic [bits-1:0] mem_din_a_q,  mem_din_a_d;
  logic            mem_we_b_q,   mem_we_b_d;
  logic [2:0]      mem_addr_b_q, mem_addr_b_d;
  logic [bits-1:0] mem_din_b_q,  mem_din_b_d;

  // Stage N+2: responses
  logic            rsp_valid_0_q, rsp_valid_0_d;
  logic            rsp_valid_1_q, rsp_valid_1_d;
  logic [bits-1:0] rdata_0_q,     rdata_0_d;
  logic [bits-1:0] rdata_1_q,     rdata_1_d;

`ifdef MPR_CLR_EN
  typedef enum logic [2:0] {
    IDLE,
    CLR0,
    CLR1,
    CLR2,
    CLR3
  } clr_state_e;

  clr_state_e state_q, state_d;
  logic       busy_q, busy_d;
  logic       clr_done_q, clr_done_d;
  logic [1:0] clr_idx;                  // entry pair being cleared in the next cycle
`else
  logic clr_start_unused;
  assign clr_start_unused = clr_start;
`endif

  // Grant and conflict resolution. Grants are combinational, so they can
  // only be suppressed by state that is already registered or is an input.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves it unassigned. That is what keeps latches from being inferred.
    conflict = bus.req_0 && bus.req_1 && (bus.addr_0 == bus.addr_1) &&
               (bus.we_0 || bus.we_1);
`ifdef MPR_CLR_EN
    blocked  = rst || busy_q || clr_start;
`else
    blocked  = rst;
`endif
    gnt_0    = bus.req_0 && !blocked && !(conflict &&  prio_q);
    gnt_1    = bus.req_1 && !blocked && !(conflict && !prio_q);
    // The pointer moves only when a conflict was actually arbitrated.
    prio_d   = prio_q ^ (conflict && !blocked);
  end

`ifdef MPR_CLR_EN
  // Clear sequencer: next state, registered busy/clr_done, and the entry pair to clear.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_start) state_d = CLR0;
      CLR0:    state_d = CLR1;
      CLR1:    state_d = CLR2;
      CLR2:    state_d = CLR3;
      CLR3:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    clr_done_d = (state_q == CLR3);
    case (state_d)
      CLR1:    clr_idx = 2'd1;
      CLR2:    clr_idx = 2'd2;
      CLR3:    clr_idx = 2'd3;
      default: clr_idx = 2'd0;
    endcase
  end

  // Clear FSM state and its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end
`endif

  // Next values for the memory-port registers and the response stage.
  always_comb begin
    s1_vld_0_d   = gnt_0;
    s1_vld_1_d   = gnt_1;

    mem_we_a_d   = 1'b0;
    mem_addr_a_d = mem_addr_a_q;
    mem_din_a_d  = mem_din_a_q;
    mem_we_b_d   = 1'b0;
    mem_addr_b_d = mem_addr_b_q;
    mem_din_b_d  = mem_din_b_q;

    if (gnt_0) begin
      mem_we_a_d   = bus.we_0;
      mem_addr_a_d = bus.addr_0;
      if (bus.we_0) mem_din_a_d = bus.wdata_0;
    end
    if (gnt_1) begin
      mem_we_b_d   = bus.we_1;
      mem_addr_b_d = bus.addr_1;
      if (bus.we_1) mem_din_b_d = bus.wdata_1;
    end

`ifdef MPR_CLR_EN
    // Grants are blocked in the clr_start cycle and all through CLR0..CLR3.
    // As a result, the last client access has already left the ports when
    // CLR0 drives them, and the clear writes never collide with stage N+1.
    if (state_d != IDLE) begin
      mem_we_a_d   = 1'b1;
      mem_addr_a_d = {clr_idx, 1'b0};
      mem_din_a_d  = '0;
      mem_we_b_d   = 1'b1;
      mem_addr_b_d = {clr_idx, 1'b1};
      mem_din_b_d  = '0;
    end
`endif

    // The memory port is combinational. It is sampled at the edge that ends
    // stage N+1, which is the same edge on which a write lands.
    rsp_valid_0_d = s1_vld_0_q;
    rsp_valid_1_d = s1_vld_1_q;
    rdata_0_d     = (s1_vld_0_q && !mem_we_a_q) ? bus.mem_dout_a : '0;
    rdata_1_d     = (s1_vld_1_q && !mem_we_b_q) ? bus.mem_dout_b : '0;
  end

  // Pipeline, priority and memory-port registers. The synchronous reset
  // drops anything in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of statement order.
    if (rst) begin
      prio_q        <= 1'b0;
      s1_vld_0_q    <= 1'b0;
      s1_vld_1_q    <= 1'b0;
      mem_we_a_q    <= 1'b0;
      mem_addr_a_q  <= '0;
      mem_din_a_q   <= '0;
      mem_we_b_q    <= 1'b0;
      mem_addr_b_q  <= '0;
      mem_din_b_q   <= '0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rdata_0_q     <= '0;
      rdata_1_q     <= '0;
    end else begin
      prio_q        <= prio_d;
      s1_vld_0_q    <= s1_vld_0_d;
      s1_vld_1_q    <= s1_vld_1_d;
      mem_we_a_q    <= mem_we_a_d;
      mem_addr_a_q  <= mem_addr_a_d;
      mem_din_a_q   <= mem_din_a_d;
      mem_we_b_q    <= mem_we_b_d;
      mem_addr_b_q  <= mem_addr_b_d;
      mem_din_b_q   <= mem_din_b_d;
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
      rdata_0_q     <= rdata_0_d;
      rdata_1_q     <= rdata_1_d;
    end
  end

  assign bus.gnt_0       = gnt_0;
  assign bus.gnt_1       = gnt_1;
  assign bus.rsp_valid_0 = rsp_valid_0_q;
  assign bus.rsp_valid_1 = rsp_valid_1_q;
  assign bus.rdata_0     = rdata_0_q;
  assign bus.rdata_1     = rdata_1_q;
  assign bus.mem_we_a    = mem_we_a_q;
  assign bus.mem_addr_a  = mem_addr_a_q;
  assign bus.mem_din_a   = mem_din_a_q;
  assign bus.mem_we_b    = mem_we_b_q;
  assign bus.mem_addr_b  = mem_addr_b_q;
  assign bus.mem_din_b   = mem_din_b_q;

`ifdef MPR_CLR_EN
  assign busy     = busy_q;
  assign clr_done = clr_done_q;
`else
  assign busy     = 1'b0;
  assign clr_done = 1'b0;
`endif

endmodule

// File: tb/tb_mpr_access_ctrl.sv
// Directed testbench for mpr_access_ctrl with a behavioural 8-entry
// dual-port memory. Builds with or without MPR_CLR_EN; the clear scenarios
// are selected to match the RTL build.
module tb_mpr_access_ctrl;
  localparam int BITS = 32;

  logic clk = 1'b0;
  logic rst;
  logic clr_start;
  logic busy;
  logic clr_done;

  int n_checks = 0;
  int n_fails  = 0;

  mpr_access_ctrl_if #(.bits(BITS)) bus ();

  mpr_access_ctrl #(.bits(BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_start(clr_start),
    .busy     (busy),
    .clr_done (clr_done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  logic [BITS-1:0] mem [8];
  assign bus.mem_dout_a = mem[bus.mem_addr_a];
  assign bus.mem_dout_b = mem[bus.mem_addr_b];
  always @(posedge clk) begin
    if (bus.mem_we_a) mem[bus.mem_addr_a] <= bus.mem_din_a;
    if (bus.mem_we_b) mem[bus.mem_addr_b] <= bus.mem_din_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'd0, b};
  endfunction

  function automatic logic gnt_of(input int ch);
    return (ch == 0) ? bus.gnt_0 : bus.gnt_1;
  endfunction

  function automatic logic rsp_of(input int ch);
    return (ch == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1;
  endfunction

  function automatic logic [31:0] rdata_of(input int ch);
    return (ch == 0) ? bus.rdata_0 : bus.rdata_1;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic r, input logic w,
                       input logic [2:0] a, input logic [31:0] d);
    if (ch == 0) begin
      bus.req_0 = r; bus.we_0 = w; bus.addr_0 = a; bus.wdata_0 = d;
    end else begin
      bus.req_1 = r; bus.we_1 = w; bus.addr_1 = a; bus.wdata_1 = d;
    end
  endtask

  // Single uncontended access. It starts in cycle N and returns in cycle N+2
  // after checking the grant, the response pulse and the read data.
  task automatic access(input int ch, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input string tag);
    drive(ch, 1'b1, w, a, d);
    #1;
    check({tag, " gnt"}, b2w(gnt_of(ch)), 32'd1);
    cyc();
    drive(ch, 1'b0, 1'b0, a, d);
    cyc();
    check({tag, " rsp_valid"}, b2w(rsp_of(ch)), 32'd1);
    check({tag, " rdata"}, rdata_of(ch), exp);
  endtask

`ifdef MPR_CLR_EN
  // Write 0xFFFFFFFF to all 8 entries, two per cycle, then let the last
  // write land.
  task automatic fill_ones();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b1, 3'(2 * i),     32'hFFFF_FFFF);
      drive(1, 1'b1, 1'b1, 3'(2 * i + 1), 32'hFFFF_FFFF);
      cyc();
    end
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    rst       = 1'b1;
    clr_start = 1'b0;
    drive(0, 1'b1, 1'b0, 3'd0, 32'd0);   // a request during reset must not be granted
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc();
    cyc();
    check("rst gnt_0",       b2w(bus.gnt_0),       32'd0);
    check("rst rsp_valid_0", b2w(bus.rsp_valid_0), 32'd0);
    check("rst rdata_0",     bus.rdata_0,          32'd0);
    check("rst mem_we_a",    b2w(bus.mem_we_a),    32'd0);
    check("rst mem_addr_b",  32'(bus.mem_addr_b),  32'd0);
    check("rst mem_din_a",   bus.mem_din_a,        32'd0);
    check("rst busy",        b2w(busy),            32'd0);
    check("rst clr_done",    b2w(clr_done),        32'd0);
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    rst = 1'b0;
    cyc();

    // ---------------- write then read-back on channel 0 ----------------
    drive(0, 1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF);
    #1;
    check("wr3 gnt_0", b2w(bus.gnt_0), 32'd1);
    cyc();                                                    // N+1
    check("wr3 mem_we_a",    b2w(bus.mem_we_a),   32'd1);
    check("wr3 mem_addr_a",  32'(bus.mem_addr_a), 32'd3);
    check("wr3 mem_din_a",   bus.mem_din_a,       32'hDEAD_BEEF);
    check("wr3 rsp early",   b2w(bus.rsp_valid_0), 32'd0);
    drive(0, 1'b1, 1'b0, 3'd3, 32'd0);
    #1;
    check("rd3 gnt_0", b2w(bus.gnt_0), 32'd1);
    cyc();                                                    // N+2
    check("wr3 rsp_valid_0", b2w(bus.rsp_valid_0), 32'd1);
    check("wr3 rdata_0",     bus.rdata_0,          32'd0);
    check("rd3 mem_we_a",    b2w(bus.mem_we_a),    32'd0);
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc();                                                    // N+3
    check("rd3 rsp_valid_0", b2w(bus.rsp_valid_0), 32'd1);
    check("rd3 rdata_0",     bus.rdata_0,          32'hDEAD_BEEF);
    cyc();
    check("rd3 rsp done",    b2w(bus.rsp_valid_0), 32'd0);

    // ---------------- write/write conflict on entry 5 ----------------
    drive(0, 1'b1, 1'b1, 3'd5, 32'h11);
    drive(1, 1'b1, 1'b1, 3'd5, 32'h22);
    #1;
    check("cf1 gnt_0", b2w(bus.gnt_0), 32'd1);
    check("cf1 gnt_1", b2w(bus.gnt_1), 32'd0);
    cyc();
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    #1;
    check("cf1 late gnt_1", b2w(bus.gnt_1),     32'd1);
    check("cf1 mem_din_a",  bus.mem_din_a,      32'h11);
    check("cf1 mem_we_b",   b2w(bus.mem_we_b),  32'd0);
    cyc();
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    check("cf1 mem_we_b late",  b2w(bus.mem_we_b),  32'd1);
    check("cf1 mem_addr_b",     32'(bus.mem_addr_b), 32'd5);
    check("cf1 mem_din_b",      bus.mem_din_b,       32'h22);
    cyc();
    cyc();
    access(0, 1'b0, 3'd5, 32'd0, 32'h22, "e5 after cf1");
    // The pointer moved after cf1, so channel 1 wins this time.
    drive(0, 1'b1, 1'b1, 3'd5, 32'h33);
    drive(1, 1'b1, 1'b1, 3'd5, 32'h44);
    #1;
    check("cf2 gnt_0", b2w(bus.gnt_0), 32'd0);
    check("cf2 gnt_1", b2w(bus.gnt_1), 32'd1);
    cyc();
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    #1;
    check("cf2 late gnt_0", b2w(bus.gnt_0), 32'd1);
    cyc();
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc();
    cyc();
    access(1, 1'b0, 3'd5, 32'd0, 32'h33, "e5 after cf2");

    // ---------------- two reads of the same entry ----------------
    access(1, 1'b1, 3'd2, 32'hA5, 32'd0, "wr2");
    drive(0, 1'b1, 1'b0, 3'd2, 32'd0);
    drive(1, 1'b1, 1'b0, 3'd2, 32'd0);
    #1;
    check("rr2 gnt_0", b2w(bus.gnt_0), 32'd1);
    check("rr2 gnt_1", b2w(bus.gnt_1), 32'd1);
    cyc();
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc();
    check("rr2 rsp_valid_0", b2w(bus.rsp_valid_0), 32'd1);
    check("rr2 rsp_valid_1", b2w(bus.rsp_valid_1), 32'd1);
    check("rr2 rdata_0",     bus.rdata_0,          32'hA5);
    check("rr2 rdata_1",     bus.rdata_1,          32'hA5);

    // ---------------- different addresses, then cross reads ----------------
    drive(0, 1'b1, 1'b1, 3'd6, 32'h66);
    drive(1, 1'b1, 1'b1, 3'd7, 32'h77);
    #1;
    check("ww67 gnt_0", b2w(bus.gnt_0), 32'd1);
    check("ww67 gnt_1", b2w(bus.gnt_1), 32'd1);
    cyc();
    drive(0, 1'b1, 1'b0, 3'd7, 32'd0);
    drive(1, 1'b1, 1'b0, 3'd6, 32'd0);
    #1;
    check("xr gnt_0", b2w(bus.gnt_0), 32'd1);
    check("xr gnt_1", b2w(bus.gnt_1), 32'd1);
    cyc();
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc();
    check("xr rdata_0 (entry 7)", bus.rdata_0, 32'h77);
    check("xr rdata_1 (entry 6)", bus.rdata_1, 32'h66);

    // ---------------- read right after the other channel's write ----------------
    drive(0, 1'b1, 1'b1, 3'd1, 32'h1234);
    #1;
    check("raw wr gnt_0", b2w(bus.gnt_0), 32'd1);
    cyc();
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 3'd1, 32'd0);
    #1;
    check("raw rd gnt_1", b2w(bus.gnt_1), 32'd1);
    cyc();
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc();
    check("raw rsp_valid_1", b2w(bus.rsp_valid_1), 32'd1);
    check("raw rdata_1",     bus.rdata_1,          32'h1234);

    // ---------------- reset with a request in flight; priority restarts at ch0 ----------------
    drive(0, 1'b1, 1'b1, 3'd4, 32'h40);
    drive(1, 1'b1, 1'b1, 3'd4, 32'h41);
    #1;
    check("cf3 gnt_0", b2w(bus.gnt_0), 32'd1);
    cyc();
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    rst = 1'b1;
    #1;
    check("rst gnt_1 held", b2w(bus.gnt_1), 32'd0);
    cyc();
    rst = 1'b0;
    check("inflight rsp dropped", b2w(bus.rsp_valid_0), 32'd0);
    check("inflight mem_we_a",    b2w(bus.mem_we_a),    32'd0);
    check("inflight mem_we_b",    b2w(bus.mem_we_b),    32'd0);
    drive(0, 1'b1, 1'b1, 3'd4, 32'h42);
    drive(1, 1'b1, 1'b1, 3'd4, 32'h43);
    #1;
    check("cf4 gnt_0", b2w(bus.gnt_0), 32'd1);
    check("cf4 gnt_1", b2w(bus.gnt_1), 32'd0);
    cyc();
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    #1;
    check("cf4 late gnt_1", b2w(bus.gnt_1), 32'd1);
    cyc();
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc();
    cyc();
    access(0, 1'b0, 3'd4, 32'd0, 32'h43, "e4 after cf4");

`ifdef MPR_CLR_EN
    // ---------------- full clear ----------------
    fill_ones();
    clr_start = 1'b1;
    drive(0, 1'b1, 1'b0, 3'd0, 32'd0);
    #1;
    check("clr start gnt_0", b2w(bus.gnt_0), 32'd0);
    cyc();
    clr_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("clr busy",       b2w(busy),            32'd1);
      check("clr gnt_0",      b2w(bus.gnt_0),       32'd0);
      check("clr mem_we_a",   b2w(bus.mem_we_a),    32'd1);
      check("clr mem_addr_a", 32'(bus.mem_addr_a),  32'(2 * k));
      check("clr mem_addr_b", 32'(bus.mem_addr_b),  32'(2 * k + 1));
      check("clr mem_din_b",  bus.mem_din_b,        32'd0);
      cyc();
    end
    #1;
    check("clr end busy",     b2w(busy),      32'd0);
    check("clr end clr_done", b2w(clr_done),  32'd1);
    check("clr end gnt_0",    b2w(bus.gnt_0), 32'd1);
    cyc();
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    check("clr_done one cycle", b2w(clr_done), 32'd0);
    cyc();
    check("post clr rsp_valid_0", b2w(bus.rsp_valid_0), 32'd1);
    check("post clr rdata_0",     bus.rdata_0,          32'd0);
    for (int i = 0; i < 8; i++)
      access(i % 2, 1'b0, 3'(i), 32'd0, 32'd0, $sformatf("cleared e%0d", i));

    // ---------------- reset during CLR1 ----------------
    fill_ones();
    clr_start = 1'b1;
    cyc();                                   // CLR0
    clr_start = 1'b0;
    cyc();                                   // CLR1
    check("abort busy in CLR1", b2w(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort busy",     b2w(busy),     32'd0);
    check("abort clr_done", b2w(clr_done), 32'd0);
    cyc();
    check("abort clr_done later", b2w(clr_done), 32'd0);
    access(0, 1'b0, 3'd0, 32'd0, 32'd0, "abort e0");
    access(1, 1'b0, 3'd1, 32'd0, 32'd0, "abort e1");
    for (int i = 4; i < 8; i++)
      access(i % 2, 1'b0, 3'(i), 32'd0, 32'hFFFF_FFFF, $sformatf("abort kept e%0d", i));
`else
    // ---------------- clr_start has no effect without the clear feature ----------------
    clr_start = 1'b1;
    drive(0, 1'b1, 1'b0, 3'd7, 32'd0);
    #1;
    check("noclr gnt_0", b2w(bus.gnt_0), 32'd1);
    check("noclr busy",  b2w(busy),      32'd0);
    cyc();
    clr_start = 1'b0;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    check("noclr busy later", b2w(busy), 32'd0);
    cyc();
    check("noclr rsp_valid_0", b2w(bus.rsp_valid_0), 32'd1);
    check("noclr rdata_0",     bus.rdata_0,          32'h77);
    for (int i = 0; i < 6; i++) begin
      check("noclr clr_done", b2w(clr_done), 32'd0);
      check("noclr mem_we_a", b2w(bus.mem_we_a), 32'd0);
      cyc();
    end
    access(1, 1'b0, 3'd6, 32'd0, 32'h66, "noclr e6");
    access(0, 1'b0, 3'd3, 32'd0, 32'hDEAD_BEEF, "noclr e3");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mpr_access_ctrl.md
MPR_ACCESS_CTRL -- requirements
Module: mpr_access_ctrl

Interface
REQ-001 Parameter: bits, 32, data width of both client channels and both memory ports.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_0, req_1  input  1  client request, held until granted.
REQ-005 we_0, we_1  input  1  1 = write, 0 = read; qualified by req_x.
REQ-006 addr_0, addr_1  input  3  target entry 0..7.
REQ-007 wdata_0, wdata_1  input  bits  write data.
REQ-008 gnt_0, gnt_1  output  1  combinational grant; request accepted on the cycle where req_x && gnt_x.
REQ-009 rsp_valid_0, rsp_valid_1  output  1  one-cycle completion pulse per accepted request.
REQ-010 rdata_0, rdata_1  output  bits  read data, valid with rsp_valid_x on reads; 0 on writes.
REQ-011 mem_we_a, mem_we_b  output  1  memory write enables (channel 0 -> port a, channel 1 -> port b, fixed).
REQ-012 mem_addr_a, mem_addr_b  output  3  memory addresses.
REQ-013 mem_din_a, mem_din_b  output  bits  memory write data.
REQ-014 mem_dout_a, mem_dout_b  input  bits  memory combinational read data for the driven address.
REQ-015 clr_start  input  1  request to zero all 8 entries.
REQ-016 busy, clr_done  output  1  clear in progress; one-cycle clear-complete pulse.

Function
REQ-017 Pipeline: accept at cycle N -> mem_* driven from registers during N+1 -> rsp_valid_x at N+2; one new request per channel per cycle.
REQ-018 Memory write occurs at the clk edge ending cycle N+1; read data captured from mem_dout_x at that edge into rdata_x.
REQ-019 mem_we_x SHALL be 1 only in the cycle after an accepted write; mem_addr_x and mem_din_x hold last values otherwise.
REQ-020 gnt_x = req_x && !busy && !clr_start && !lost_conflict_x.
REQ-021 Conflict: req_0 && req_1 with addr_0 == addr_1 and (we_0 || we_1); only the priority channel is granted.
REQ-022 Priority pointer resets to channel 0 and toggles after each resolved conflict (round-robin); no toggle without conflict.
REQ-023 Two reads to the same address, or any accesses to different addresses, both granted in the same cycle.
REQ-024 Read in cycle N+1 to an entry written by the other channel in cycle N returns the new data (ordering by acceptance cycle).
REQ-025 Clear FSM states IDLE -> CLR0..CLR3 -> IDLE; clr_start in IDLE (sampled at edge) enters CLR0.
REQ-026 In CLRk: port a writes 0 to entry 2k, port b writes 0 to entry 2k+1; busy = 1 in CLR0..CLR3.
REQ-027 clr_done pulses in the first IDLE cycle after CLR3; grants resume that cycle.
REQ-028 clr_start while busy SHALL be ignored; clr_start with req_x in same cycle: clear wins, gnt_x = 0.
REQ-029 Requests accepted before clr_start complete normally; CLR0 mem writes follow their N+1 stage, no port overlap (clear entry waits one cycle if stage N+1 active).

Reset
REQ-030 On rst: gnt, rsp_valid, rdata, mem_we, mem_addr, mem_din, busy, clr_done = 0; FSM = IDLE; priority = channel 0.
REQ-031 Requests in flight at rst are dropped: no rsp_valid and no mem_we after rst.
REQ-032 rst asserted mid-clear aborts clear without clr_done; already-written entries stay zero.

Configuration
REQ-033 Macro MPR_CLR_EN: defined -> clear FSM per REQ-025..029 compiled in.
REQ-034 Undefined -> clr_start ignored, busy and clr_done tied 0, no clear FSM logic; all other behaviour identical.

Verification
REQ-035 ch0 write addr 3 = 0xDEADBEEF at N, ch0 read addr 3 at N+1 -> rsp_valid_0 at N+3, rdata_0 = 0xDEADBEEF.
REQ-036 Both write addr 5 same cycle (0x11, 0x22) after reset -> gnt_0 = 1, gnt_1 = 0; next cycle gnt_1 = 1; final entry 5 = 0x22; next conflict grants ch1 first.
REQ-037 ch0 read addr 2, ch1 read addr 2 same cycle with entry 2 = 0xA5 -> both granted, both rdata = 0xA5 two cycles later.
REQ-038 Fill entries with 0xFFFFFFFF, pulse clr_start -> busy 4 cycles, gnt low, clr_done pulse, all 8 reads return 0 (MPR_CLR_EN defined).
REQ-039 rst during CLR1 -> busy = 0 next cycle, no clr_done, entries 0,1 = 0, entries 4..7 unchanged.
REQ-040 MPR_CLR_EN undefined: pulse clr_start with req_0 high -> gnt_0 = 1, busy stays 0, no memory clear.
